result_display: RTL and testbench
=================================

Name: result_display

Overview:
- Downstream consumer of the 4-bit adder/subtractor stage.
- Captures its sum and difference outputs when the user presses an update button.
- Drives the four-digit multiplexed seven-segment display: digits 1..0 show the sum, digits 3..2 show the difference.
- Each result displays as either signed (sign plus magnitude) or raw hex, selectable at run time.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit before the scan advances. Must be ≥ 2. Bench uses 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- update  input  1  raw push-button, asynchronous to clk, active-high.
- plus_in  input  4  A+B from the math stage, two's complement.
- minus_in  input  4  A−B from the math stage, two's complement.
- signed_mode  input  1  1 = sign+magnitude display, 0 = unsigned hex display.
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anodes, active-low, one-hot-low, registered.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (clk edge with reset=1):
  - plus_q, minus_q = 0
  - sync chain = 0
  - refresh counter = 0
  - digit index = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1
- Reset applies mid-scan with the same result; the scan restarts at index 0 on the first cycle after reset deasserts.
- Update synchronizer:
  - Three flops in series: s1 <= update, s2 <= s1, s3 <= s2.
  - load = s2 & ~s3.
  - On an edge with load=1: plus_q <= plus_in, minus_q <= minus_in.
  - If update is first sampled high at edge k, capture occurs at edge k+2.
  - Holding update high gives exactly one capture; a new capture needs update low for ≥1 sampled cycle.
  - Inputs are sampled only at the capture edge. Changes at any other time are ignored.
- Refresh counter:
  - Counts 0..REFRESH_DIV−1, then wraps to 0.
  - On the wrap edge, digit index advances mod 4 (0→1→2→3→0).
- Output register:
  - Each edge (not in reset): an and seg <= decode(current index, plus_q, minus_q, signed_mode).
  - an/seg therefore lag an index change by 1 cycle.
  - signed_mode and captured values take effect on that next registered update.
- Digit map (an bit cleared = idx):
  - idx0: low digit of plus_q.
  - idx1: sign digit of plus_q.
  - idx2: low digit of minus_q.
  - idx3: sign digit of minus_q.
- Low digit:
  - signed_mode=1: magnitude = value if bit3=0, else (0 − value) in 4 bits; 4'b1000 gives magnitude 8.
  - signed_mode=0: hex glyph of the raw 4-bit value.
- Sign digit:
  - signed_mode=1 and bit3=1: SEG_MINUS = 7'b0111111.
  - Otherwise: SEG_BLANK = 7'b1111111.
- Hex glyphs {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No overflow indication. The math stage supplies only 4 bits.

Decomposition:
- Shared package: the 16 glyph constants, SEG_BLANK, SEG_MINUS, and digit-index typedef (2 bits).
- One sub-module, hex_to_seg: purely combinational 4-bit value → 7-bit active-low glyph. Instantiated once on the selected low-digit value.
- Synchronizer, refresh counter, capture registers and output register live in result_display.

Test Plan:
- Reset: assert reset 2 cycles → an=1111, seg=1111111, dp=1 on the cycle after; after release, the first lit anode is an=1110.
- Signed capture: plus_in=0101, minus_in=1101, signed_mode=1, update high 3 cycles → capture at the expected edge. Scan shows:
  - an=1110 seg=0010010 ('5')
  - an=1101 seg=1111111 (blank)
  - an=1011 seg=0110000 ('3')
  - an=0111 seg=0111111 ('−')
- Edge magnitude: minus_in=1000, signed_mode=1, capture → an=1011 seg=0000000 ('8'); an=0111 seg=0111111.
- Unsigned mode: same captured 1101 with signed_mode=0 → an=1011 seg=0100001 ('d'); an=0111 seg=1111111. Toggling signed_mode changes the glyph within 1 cycle, with no recapture.
- Single capture: hold update high 100 cycles while plus_in changes every cycle → plus_q equals the value present at the single capture edge; the display never changes afterwards.
- Reset mid-scan: assert reset while index=2 → next cycle an=1111, seg=1111111, plus_q=minus_q=0; after release, the scan restarts at an=1110 showing '0'.

Source files
------------

// File: rtl/result_display_pkg.sv
// result_display_pkg: seven-segment glyphs and digit-index type shared by the display slice.
package result_display_pkg;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/result_display_hex_to_seg.sv
// hex_to_seg: 4-bit value to active-low {g..a} glyph.
module hex_to_seg
  import result_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph
);
  assign glyph = HEX_GLYPH[value];
endmodule

// File: rtl/result_display.sv
// result_display: captures sum/difference on a button edge and scans them onto a 4-digit display.
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [3:0] plus_in,
  input  logic [3:0] minus_in,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic s1, s2, s3, load, wrap, neg;
  logic [3:0] plus_q, minus_q, sel, low;
  logic [CW-1:0] cnt;
  digit_idx_t idx;
  logic [6:0] glyph, seg_n;
  logic [3:0] an_n;
  assign dp = 1'b1;
  assign load = s2 & ~s3;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  // idx[1] picks the difference pair, idx[0] picks the sign digit of the pair
  always_comb begin
    sel = idx[1] ? minus_q : plus_q;
    neg = signed_mode & sel[3];
    low = neg ? 4'd0 - sel : sel;
    seg_n = idx[0] ? (neg ? SEG_MINUS : SEG_BLANK) : glyph;
    an_n = ~(4'b0001 << idx);
  end
  hex_to_seg u_hex (.value(low), .glyph(glyph));
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, s3} <= '0;
      plus_q <= '0;
      minus_q <= '0;
      cnt <= '0;
      idx <= '0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      {s1, s2, s3} <= {update, s1, s2};
      if (load) begin
        plus_q <= plus_in;
        minus_q <= minus_in;
      end
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      an <= an_n;
      seg <= seg_n;
    end
  end
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed and random stimulus checked each cycle against a behavioural display model.
module tb_result_display;
  localparam int DIV = 4;
  logic clk = 0, reset = 1, update = 0, signed_mode = 0;
  logic [3:0] plus_in = 0, minus_in = 0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp;
  int compared = 0, mismatched = 0;
  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int pv, mv, t;
  bit u1, u2, u3;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .update(update), .plus_in(plus_in), .minus_in(minus_in),
    .signed_mode(signed_mode), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic expect_digit(input int d, input int p, input int m, input bit sm);
    int v, mag;
    bit negative;
    v = (d < 2) ? p : m;
    negative = sm && v >= 8;
    mag = (sm && v >= 8) ? 16 - v : v;
    exp_an = 4'hF ^ (4'b0001 << d);
    exp_seg = (d % 2 == 1) ? (negative ? 7'b0111111 : 7'b1111111) : glyph[mag];
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      pv = 0; mv = 0; t = 0;
      {u1, u2, u3} = 3'b000;
      exp_an = 4'b1111;
      exp_seg = 7'b1111111;
    end else begin
      expect_digit((t / DIV) % 4, pv, mv, signed_mode);
      if (u2 && !u3) begin
        pv = int'(plus_in);
        mv = int'(minus_in);
      end
      {u3, u2, u1} = {u2, u1, update};
      t++;
    end
    #1;
    compared += 3;
    assert (an === exp_an) else begin
      mismatched++;
      $error("FAIL an t=%0d observed=%b expected=%b", t, an, exp_an);
    end
    assert (seg === exp_seg) else begin
      mismatched++;
      $error("FAIL seg t=%0d an=%b observed=%b expected=%b", t, an, seg, exp_seg);
    end
    assert (dp === 1'b1) else begin
      mismatched++;
      $error("FAIL dp observed=%b expected=1", dp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1; cycles(2);
    reset = 0; cycles(3);
    plus_in = 4'b0101; minus_in = 4'b1101; signed_mode = 1;
    update = 1; cycles(3);
    update = 0; plus_in = 4'b0000; minus_in = 4'b0111;
    cycles(4 * DIV + 3);
    minus_in = 4'b1000; update = 1; cycles(2);
    update = 0; minus_in = 4'b0001; cycles(4 * DIV + 3);
    minus_in = 4'b1101; update = 1; cycles(1);
    update = 0; cycles(4);
    signed_mode = 0; cycles(4 * DIV);
    for (int i = 0; i < 4 * DIV; i++) begin
      signed_mode = ~signed_mode;
      step();
    end
    update = 1;
    for (int i = 0; i < 100; i++) begin
      plus_in = 4'($urandom);
      minus_in = 4'($urandom);
      step();
    end
    update = 0; cycles(2 * DIV + 1);
    while ((t / DIV) % 4 != 2) step();
    reset = 1; cycles(1);
    reset = 0; cycles(4 * DIV);
    for (int i = 0; i < 1500; i++) begin
      plus_in = 4'($urandom);
      minus_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) update = ~update;
      if ($urandom_range(0, 29) == 0) signed_mode = ~signed_mode;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 0; update = 0; cycles(4 * DIV);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
